subtractor32_seq: RTL

//   Multi-cycle unsigned/two's-complement subtractor: diff = a - b - bin.

---
 rtl/subtractor32_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/subtractor32_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle, with the
// borrow chained through a register. valid/ready handshake on both sides.
module subtractor32_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_zero,
    output logic             o_ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t            r_state;
    logic [IdxW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_work;    // partial difference, filled one chunk per cycle
    logic              r_borrow;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bout;
    logic              r_zero;
    logic              r_ovf;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_sum;
    logic [WIDTH-1:0]  w_full;
    logic              w_borrow_next;

    // Current chunk: a + ~b + !borrow; carry-out of 0 means a borrow into the next chunk.
    always_comb begin
        w_a_chunk     = r_a[r_idx*CHUNK +: CHUNK];
        w_b_chunk     = r_b[r_idx*CHUNK +: CHUNK];
        w_sum         = {1'b0, w_a_chunk} + {1'b0, ~w_b_chunk} + {{CHUNK{1'b0}}, ~r_borrow};
        w_borrow_next = ~w_sum[CHUNK];
        w_full        = r_work;
        w_full[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // Control FSM with registered result outputs; reset aborts any op in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_work      <= '0;
            r_borrow    <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_borrow <= i_bin;
                        r_idx    <= '0;
                        r_state  <= StBusy;
                    end
                end
                StBusy: begin
                    r_work   <= w_full;
                    r_borrow <= w_borrow_next;
                    if (r_idx == LastIdx) begin
                        r_idx       <= '0;
                        r_state     <= StDone;
                        r_out_valid <= 1'b1;
                        r_diff      <= w_full;
                        r_bout      <= w_borrow_next;
                        r_zero      <= (w_full == '0);
                        r_ovf       <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                       (w_full[WIDTH-1] != r_a[WIDTH-1]);
                    end else begin
                        r_idx <= r_idx + IdxW'(1);
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Ready is gated by reset so no operand is taken on a reset edge.
    always_comb begin
        o_in_ready  = (r_state == StIdle) && !i_rst;
        o_out_valid = r_out_valid;
        o_diff      = r_diff;
        o_bout      = r_bout;
        o_zero      = r_zero;
        o_ovf       = r_ovf;
    end

endmodule
